// File: rtl/mem_bridge.sv
// mem_bridge: turns 8/16-bit memory requests into byte accesses on a fixed-wait-state SRAM.
// Optional build macro ALIGN_CHECK_EN rejects size 0/3 and odd-address words with O_error.
module mem_bridge #(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                  I_clk,
    input  logic                  I_reset,
    input  logic                  I_exec,
    input  logic                  I_write,
    input  logic [1:0]            I_size,
    input  logic [15:0]           I_addr,
    input  logic [15:0]           I_data,
    output logic [15:0]           O_data,
    output logic                  O_data_ready,
    output logic                  O_ready,
`ifdef ALIGN_CHECK_EN
    output logic                  O_error,
`endif
    output logic [ADDR_WIDTH-1:0] O_sram_addr,
    output logic                  O_sram_oe,
    output logic                  O_sram_we,
    output logic [7:0]            O_sram_data,
    input  logic [7:0]            I_sram_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              wait_q, wait_d;
    logic [15:0]             rdata_q, rdata_d;
    logic                    write_q, write_d;
    logic                    word_q, word_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [15:0]             wdata_q, wdata_d;
`ifdef ALIGN_CHECK_EN
    logic                    err_q, err_d;
`endif

    logic                    req_word;
    logic                    req_bad;
    logic                    access_last;
    logic                    in_access;

    always_comb begin
        req_word    = (I_size == 2'd2) || (I_size == 2'd3);
        req_bad     = 1'b0;
`ifdef ALIGN_CHECK_EN
        req_bad     = (I_size == 2'd0) || (I_size == 2'd3) ||
                      ((I_size == 2'd2) && I_addr[0]);
`endif
        access_last = (wait_q == 4'(WAIT_STATES));
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        write_d = write_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef ALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (I_exec) begin
                    write_d = I_write;
                    word_d  = req_word;
                    addr_d  = I_addr[ADDR_WIDTH-1:0];
                    wdata_d = I_data;
                    wait_d  = 4'd0;
`ifdef ALIGN_CHECK_EN
                    err_d   = req_bad;
`endif
                    if (req_bad) begin
                        // Rejected requests skip the SRAM entirely; a rejected read returns zero.
                        state_d = DONE;
                        if (!I_write) begin
                            rdata_d = 16'h0000;
                        end
                    end else begin
                        state_d = LO;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LO: begin
                if (access_last) begin
                    wait_d = 4'd0;
                    if (!write_q) begin
                        rdata_d[7:0] = I_sram_data;
                        if (!word_q) begin
                            rdata_d[15:8] = 8'h00;
                        end
                    end
                    state_d = word_q ? HI : DONE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            HI: begin
                if (access_last) begin
                    wait_d = 4'd0;
                    if (!write_q) begin
                        rdata_d[15:8] = I_sram_data;
                    end
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and the visible read-data register take the reset.
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            rdata_q <= 16'h0000;
`ifdef ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
`ifdef ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Latched request fields are only observed outside IDLE, so they need no reset.
    always_ff @(posedge I_clk) begin
        write_q <= write_d;
        word_q  <= word_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    always_comb begin
        in_access    = (state_q == LO) || (state_q == HI);
        O_ready      = (state_q == IDLE) || (state_q == DONE);
        O_data       = rdata_q;
        O_data_ready = (state_q == DONE) && !write_q;
        O_sram_oe    = in_access && !write_q;
        O_sram_we    = in_access && write_q;
        O_sram_addr  = '0;
        O_sram_data  = 8'h00;
        if (state_q == LO) begin
            O_sram_addr = addr_q;
            O_sram_data = wdata_q[7:0];
        end else if (state_q == HI) begin
            O_sram_addr = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            O_sram_data = wdata_q[15:8];
        end
`ifdef ALIGN_CHECK_EN
        O_error      = (state_q == DONE) && err_q;
`endif
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed cases plus randomized requests
// against a byte-array memory model and latency formulas.
module tb_mem_bridge;

    localparam int WS = 1;

    logic        I_clk = 1'b0;
    logic        I_reset;
    logic        I_exec;
    logic        I_write;
    logic [1:0]  I_size;
    logic [15:0] I_addr;
    logic [15:0] I_data;
    logic [15:0] O_data;
    logic        O_data_ready;
    logic        O_ready;
`ifdef ALIGN_CHECK_EN
    logic        O_error;
`endif
    logic [15:0] O_sram_addr;
    logic        O_sram_oe;
    logic        O_sram_we;
    logic [7:0]  O_sram_data;
    logic [7:0]  I_sram_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  sram      [0:65535];
    logic [7:0]  model_mem [0:65535];
    logic [15:0] last_rd;

    mem_bridge #(
        .ADDR_WIDTH (16),
        .WAIT_STATES(WS)
    ) dut (
        .I_clk       (I_clk),
        .I_reset     (I_reset),
        .I_exec      (I_exec),
        .I_write     (I_write),
        .I_size      (I_size),
        .I_addr      (I_addr),
        .I_data      (I_data),
        .O_data      (O_data),
        .O_data_ready(O_data_ready),
        .O_ready     (O_ready),
`ifdef ALIGN_CHECK_EN
        .O_error     (O_error),
`endif
        .O_sram_addr (O_sram_addr),
        .O_sram_oe   (O_sram_oe),
        .O_sram_we   (O_sram_we),
        .O_sram_data (O_sram_data),
        .I_sram_data (I_sram_data)
    );

    always #5 I_clk = ~I_clk;

    function automatic logic [7:0] init_byte(input int i);
        if (i == 16'h0010) return 8'h34;
        if (i == 16'h0011) return 8'h12;
        return 8'(i * 37 + 11) ^ 8'(i >> 8);
    endfunction

    // SRAM: combinational read while oe, write on the clock edge while we.
    assign I_sram_data = O_sram_oe ? sram[O_sram_addr] : 8'h5A;

    initial begin
        for (int i = 0; i < 65536; i++) sram[i] = init_byte(i);
        forever begin
            @(posedge I_clk);
            if (O_sram_we) sram[O_sram_addr] = O_sram_data;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge I_clk) begin
        if (!I_reset) begin
            if (O_sram_oe || O_sram_we)
                check_val("oe_we_exclusive", 32'(O_sram_oe & O_sram_we), 32'd0);
            if (!O_ready)
                check_val("data_ready_while_busy", 32'(O_data_ready), 32'd0);
        end
    end

    // Issue one request from a ready cycle; returns at the DONE cycle with I_exec low.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic [15:0] a,
                          input logic [15:0] d, input bit noise);
        int          k;
        int          exp_lat;
        bit          saw_acc;
        bit          done;
        bit          word;
        bit          exp_err;
        logic [15:0] a1;
        logic [15:0] exp_rd;
        word    = (sz == 2'd2) || (sz == 2'd3);
        exp_err = 1'b0;
`ifdef ALIGN_CHECK_EN
        exp_err = (sz == 2'd0) || (sz == 2'd3) || (word && a[0]);
`endif
        a1      = a + 16'd1;
        exp_lat = exp_err ? 1 : (word ? 3 + 2 * WS : 2 + WS);
        I_exec  = 1'b1;
        I_write = wr;
        I_size  = sz;
        I_addr  = a;
        I_data  = d;
        @(posedge I_clk);
        @(negedge I_clk);
        I_exec  = 1'b0;
        k       = 1;
        saw_acc = 1'b0;
        done    = 1'b0;
        while (!done && k <= 100) begin
            if (O_ready) begin
                done = 1'b1;
            end else begin
                saw_acc = saw_acc | O_sram_oe | O_sram_we;
                if (noise) begin
                    I_exec  = 1'($urandom);
                    I_write = 1'($urandom);
                    I_size  = 2'($urandom);
                    I_addr  = 16'($urandom);
                    I_data  = 16'($urandom);
                end
                @(negedge I_clk);
                k++;
            end
        end
        I_exec = 1'b0;
        check_val("latency", 32'(k), 32'(exp_lat));
        check_val("data_ready_at_done", 32'(O_data_ready), 32'(!wr));
`ifdef ALIGN_CHECK_EN
        check_val("error_flag", 32'(O_error), 32'(exp_err));
`endif
        if (exp_err) begin
            check_val("no_sram_access_on_error", 32'(saw_acc), 32'd0);
            if (!wr) last_rd = 16'h0000;
            check_val("error_rdata", 32'(O_data), 32'(last_rd));
        end else if (wr) begin
            model_mem[a] = d[7:0];
            if (word) model_mem[a1] = d[15:8];
            check_val("sram_byte_a", 32'(sram[a]), 32'(model_mem[a]));
            check_val("sram_byte_a1", 32'(sram[a1]), 32'(model_mem[a1]));
            check_val("rdata_hold_on_write", 32'(O_data), 32'(last_rd));
        end else begin
            exp_rd  = word ? {model_mem[a1], model_mem[a]} : {8'h00, model_mem[a]};
            last_rd = exp_rd;
            check_val("read_data", 32'(O_data), 32'(exp_rd));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge I_clk);
            check_val("idle_ready", 32'(O_ready), 32'd1);
            check_val("idle_no_data_ready", 32'(O_data_ready), 32'd0);
            check_val("idle_rdata_hold", 32'(O_data), 32'(last_rd));
            check_val("idle_no_strobe", 32'({O_sram_oe, O_sram_we}), 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) model_mem[i] = init_byte(i);
        last_rd = 16'h0000;
        I_reset = 1'b1;
        I_exec  = 1'b0;
        I_write = 1'b0;
        I_size  = 2'd0;
        I_addr  = 16'h0000;
        I_data  = 16'h0000;
        repeat (3) @(negedge I_clk);

        check_val("reset_ready", 32'(O_ready), 32'd1);
        check_val("reset_data", 32'(O_data), 32'd0);
        check_val("reset_data_ready", 32'(O_data_ready), 32'd0);
        check_val("reset_oe_we", 32'({O_sram_oe, O_sram_we}), 32'd0);
        check_val("reset_sram_addr", 32'(O_sram_addr), 32'd0);
        check_val("reset_sram_data", 32'(O_sram_data), 32'd0);
`ifdef ALIGN_CHECK_EN
        check_val("reset_error", 32'(O_error), 32'd0);
`endif
        I_reset = 1'b0;

        do_req(1'b0, 2'd2, 16'h0010, 16'h0000, 1'b0);
        check_val("word_read_0010", 32'(O_data), 32'h1234);
        check_val("ready_with_data_ready", 32'(O_ready & O_data_ready), 32'd1);
        idle(1);

        do_req(1'b1, 2'd1, 16'h0020, 16'h00AB, 1'b0);
        check_val("byte_write_neighbour", 32'(sram[16'h0021]), 32'(init_byte(16'h0021)));
        idle(1);
        do_req(1'b0, 2'd1, 16'h0020, 16'h0000, 1'b0);
        check_val("byte_read_0020", 32'(O_data), 32'h00AB);
        idle(2);

        do_req(1'b1, 2'd2, 16'hFFFF, 16'hBEEF, 1'b0);
        idle(1);
        do_req(1'b0, 2'd2, 16'hFFFF, 16'h0000, 1'b0);
`ifndef ALIGN_CHECK_EN
        check_val("wrap_ffff", 32'(sram[16'hFFFF]), 32'hEF);
        check_val("wrap_0000", 32'(sram[16'h0000]), 32'hBE);
        check_val("wrap_word_read", 32'(O_data), 32'hBEEF);
`endif

        // Back-to-back chain starting from the DONE cycle above, with exec noise while busy.
        do_req(1'b0, 2'd2, 16'h0010, 16'h0000, 1'b1);
        do_req(1'b1, 2'd2, 16'h0004, 16'hC0DE, 1'b1);
        do_req(1'b0, 2'd1, 16'h0005, 16'h0000, 1'b1);
        do_req(1'b0, 2'd2, 16'h0004, 16'h0000, 1'b0);
        check_val("b2b_word_read", 32'(O_data), 32'hC0DE);
        idle(1);

        // Reset during the HI half of a word read aborts it.
        I_exec  = 1'b1;
        I_write = 1'b0;
        I_size  = 2'd2;
        I_addr  = 16'h0040;
        @(posedge I_clk);
        @(negedge I_clk);
        I_exec = 1'b0;
        repeat (WS + 1) @(negedge I_clk);
        check_val("hi_oe", 32'(O_sram_oe), 32'd1);
        check_val("hi_addr", 32'(O_sram_addr), 32'h0041);
        I_reset = 1'b1;
        @(posedge I_clk);
        @(negedge I_clk);
        check_val("abort_ready", 32'(O_ready), 32'd1);
        check_val("abort_oe", 32'(O_sram_oe), 32'd0);
        check_val("abort_data_ready", 32'(O_data_ready), 32'd0);
        check_val("abort_data", 32'(O_data), 32'd0);
        I_reset = 1'b0;
        last_rd = 16'h0000;
        idle(3);

`ifdef ALIGN_CHECK_EN
        do_req(1'b0, 2'd2, 16'h0003, 16'h0000, 1'b0);
        check_val("misaligned_rdata_zero", 32'(O_data), 32'd0);
        idle(1);
        do_req(1'b0, 2'd3, 16'h0010, 16'h0000, 1'b0);
        do_req(1'b1, 2'd0, 16'h0022, 16'h5555, 1'b0);
        check_val("size0_write_untouched", 32'(sram[16'h0022]), 32'(init_byte(16'h0022)));
        idle(1);
`endif

        for (int t = 0; t < 300; t++) begin
            logic        wr;
            logic [1:0]  sz;
            logic [15:0] a;
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 31));
            do_req(wr, sz, a, 16'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
